calc_cu: RTL and testbench

CALC_CU -- requirements
Module: calc_cu

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_cu_if.sv | 28 ++
 rtl/calc_cu_dec.sv | 71 +++++++
 rtl/calc_cu.sv | 68 ++++++
 tb/tb_calc_cu.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM states, ALU opcodes and mux select codes for the calc control unit.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD1  = 3'd1,
        LD2  = 3'd2,
        CALC = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] XOR = 2'b11;

    localparam logic [1:0] S1_ZERO = 2'b00;
    localparam logic [1:0] S1_IN1  = 2'b01;
    localparam logic [1:0] S1_IN2  = 2'b10;
    localparam logic [1:0] S1_ALU  = 2'b11;

    localparam logic S2_ALU  = 1'b0;
    localparam logic S2_ZERO = 1'b1;

endpackage

// File: rtl/calc_cu_if.sv
// calc_cu_if: start/opcode request and datapath control bundle between calc_cu and its datapath.
interface calc_cu_if;

    logic       go;
    logic [1:0] op;
    logic [1:0] s1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic       busy;
    logic       done;

    modport master (
        input  go, op,
        output s1, wa, we, raa, rea, rab, reb, c, s2, busy, done
    );

    modport slave (
        output go, op,
        input  s1, wa, we, raa, rea, rab, reb, c, s2, busy, done
    );

endinterface

// File: rtl/calc_cu_dec.sv
// calc_cu_dec: decodes FSM state and latched opcode into datapath control signals.
module calc_cu_dec
    import calc_pkg::*;
#(
    parameter logic [1:0] A_REG = 2'b01,
    parameter logic [1:0] B_REG = 2'b10,
    parameter logic [1:0] R_REG = 2'b11
) (
    input  state_t     state,
    input  logic [1:0] op_q,
    output logic [1:0] s1,
    output logic [1:0] wa,
    output logic       we,
    output logic [1:0] raa,
    output logic       rea,
    output logic [1:0] rab,
    output logic       reb,
    output logic [1:0] c,
    output logic       s2,
    output logic       busy,
    output logic       done
);

    always_comb begin
        s1   = S1_ZERO;
        wa   = 2'b00;
        we   = 1'b0;
        raa  = 2'b00;
        rea  = 1'b0;
        rab  = 2'b00;
        reb  = 1'b0;
        c    = ADD;
        s2   = S2_ZERO;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            LD1: begin
                s1   = S1_IN1;
                wa   = A_REG;
                we   = 1'b1;
                busy = 1'b1;
            end
            LD2: begin
                s1   = S1_IN2;
                wa   = B_REG;
                we   = 1'b1;
                busy = 1'b1;
            end
            CALC: begin
                rea  = 1'b1;
                raa  = A_REG;
                reb  = 1'b1;
                rab  = B_REG;
                c    = op_q;
                s1   = S1_ALU;
                wa   = R_REG;
                we   = 1'b1;
                busy = 1'b1;
            end
            // result + 0 through the ALU presents the stored result on out
            DONE: begin
                rea  = 1'b1;
                raa  = R_REG;
                s2   = S2_ALU;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_cu.sv
// calc_cu: load-load-compute control unit; holds state and latched opcode.
// Define CALC_REPEAT_EN to let go in DONE restart directly (4-cycle back-to-back period).
module calc_cu
    import calc_pkg::*;
#(
    parameter logic [1:0] A_REG = 2'b01,
    parameter logic [1:0] B_REG = 2'b10,
    parameter logic [1:0] R_REG = 2'b11
) (
    input logic      clk,
    input logic      rst,
    calc_cu_if.master bus
);

    state_t     state;
    state_t     state_n;
    logic [1:0] op_q;
    logic       start;

`ifdef CALC_REPEAT_EN
    assign start = bus.go && (state == IDLE || state == DONE);
`else
    assign start = bus.go && state == IDLE;
`endif

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = start ? LD1 : IDLE;
            LD1:     state_n = LD2;
            LD2:     state_n = CALC;
            CALC:    state_n = DONE;
            DONE:    state_n = start ? LD1 : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= ADD;
        end else begin
            state <= state_n;
            if (start) op_q <= bus.op;
        end
    end

    calc_cu_dec #(
        .A_REG(A_REG),
        .B_REG(B_REG),
        .R_REG(R_REG)
    ) u_dec (
        .state(state),
        .op_q (op_q),
        .s1   (bus.s1),
        .wa   (bus.wa),
        .we   (bus.we),
        .raa  (bus.raa),
        .rea  (bus.rea),
        .rab  (bus.rab),
        .reb  (bus.reb),
        .c    (bus.c),
        .s2   (bus.s2),
        .busy (bus.busy),
        .done (bus.done)
    );

endmodule

// File: tb/tb_calc_cu.sv
// tb_calc_cu: directed bench for calc_cu driving a small 3-bit register-file/ALU datapath.
module tb_calc_cu;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [2:0] in1 = 3'd0;
    logic [2:0] in2 = 3'd0;
    logic [2:0] rf [4] = '{default: 3'd0};
    logic [2:0] rda, rdb, alu, mux, out;
    logic [15:0] vec;
    int checks = 0;
    int errors = 0;
    int n;
    logic saw_done;

`ifdef CALC_REPEAT_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 5;
`endif

    localparam logic [15:0] V_IDLE = 16'h0004;
    localparam logic [15:0] V_LD1  = 16'h5806;
    localparam logic [15:0] V_LD2  = 16'hA806;
    localparam logic [15:0] V_CALC = 16'hFBA6;
    localparam logic [15:0] V_DONE = 16'h0701;

    calc_cu_if bus ();

    calc_cu dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        rda = bus.rea ? rf[bus.raa] : 3'd0;
        rdb = bus.reb ? rf[bus.rab] : 3'd0;
        alu = bus.c == 2'b00 ? rda + rdb :
              bus.c == 2'b01 ? rda - rdb :
              bus.c == 2'b10 ? rda & rdb : rda ^ rdb;
        mux = bus.s1 == 2'b00 ? 3'd0 :
              bus.s1 == 2'b01 ? in1 :
              bus.s1 == 2'b10 ? in2 : alu;
        out = bus.s2 ? 3'd0 : alu;
        vec = {bus.s1, bus.wa, bus.we, bus.raa, bus.rea, bus.rab, bus.reb,
               bus.c, bus.s2, bus.busy, bus.done};
    end

    always @(posedge clk) if (bus.we) rf[bus.wa] <= mux;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
        bus.op = o;
        in1 = a;
        in2 = b;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim, output int cnt);
        cnt = 0;
        while (!bus.done && cnt < lim) begin
            @(negedge clk);
            cnt++;
        end
        chk(tag, {15'd0, bus.done}, 16'd1);
    endtask

    initial begin
        bus.go = 1'b0;
        bus.op = 2'b00;
        #1 rst = 1'b1;
        #1 chk("rst_vec", vec, V_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vec !== V_IDLE || out !== 3'd0) saw_done = 1'b1;
        end
        chk("idle_hold", {15'd0, saw_done}, 16'd0);
        chk("idle_out", {13'd0, out}, 16'd0);

        start(ADD, 3'd3, 3'd2);
        chk("add_ld1", vec, V_LD1);
        @(negedge clk);
        chk("add_ld2", vec, V_LD2);
        @(negedge clk);
        chk("add_calc", vec, V_CALC);
        @(negedge clk);
        chk("add_done", vec, V_DONE);
        chk("add_out", {13'd0, out}, 16'd5);
        @(negedge clk);
        chk("add_idle", vec, V_IDLE);

        start(SUB, 3'd2, 3'd5);
        @(negedge clk);
        @(negedge clk);
        chk("sub_c", {14'd0, bus.c}, {14'd0, SUB});
        @(negedge clk);
        chk("sub_done", {15'd0, bus.done}, 16'd1);
        chk("sub_out", {13'd0, out}, 16'd5);
        @(negedge clk);

        start(ADD, 3'd1, 3'd1);
        @(negedge clk);
        bus.op = AND;
        @(negedge clk);
        chk("oplatch_c", {14'd0, bus.c}, {14'd0, ADD});
        @(negedge clk);
        chk("oplatch_out", {13'd0, out}, 16'd2);
        @(negedge clk);

        bus.op = XOR;
        in1 = 3'd6;
        in2 = 3'd3;
        bus.go = 1'b1;
        wait_done("rep_first", 8, n);
        chk("rep_lat", n[15:0], 16'd4);
        chk("rep_out1", {13'd0, out}, 16'd5);
        @(negedge clk);
        wait_done("rep_second", 8, n);
        chk("rep_period", n[15:0] + 16'd1, PERIOD[15:0]);
        chk("rep_out2", {13'd0, out}, 16'd5);
        bus.go = 1'b0;
        @(negedge clk);
        chk("rep_idle", vec, V_IDLE);

        start(ADD, 3'd1, 3'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_calc", vec, V_CALC);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", {15'd0, bus.we}, 16'd0);
        chk("rst_mid_s2", {15'd0, bus.s2}, 16'd1);
        chk("rst_mid_state", {13'd0, dut.state}, {13'd0, IDLE});
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_write", {13'd0, rf[3]}, 16'd5);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        chk("rst_no_done", {15'd0, saw_done}, 16'd0);

        bus.op = ADD;
        in1 = 3'd3;
        in2 = 3'd2;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        n = 1;
        while (!bus.done && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_lat", n[15:0], 16'd4);
        chk("post_rst_out", {13'd0, out}, 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
